note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//   Playback controller for the SRAM-resident score. Fetches 16-bit instructions from SRAM
//   with a fixed wait-state read, then decodes them into notes or settings. Generates the beat
//   tick with a divider-free phase accumulator and holds each note for its duration. Sits
//   between the SRAM pins and the tone generator (freq calc + SPEAKER).
// PARAMETERS
//   CLK_HZ       50000000  input clock frequency; beat threshold = 60*CLK_HZ (32-bit)
//   DEFAULT_BPM  96        tempo loaded at reset and on START
//   SRAM_WAIT    2         cycles between address drive and data latch (>=1)
//   ADDR_W       18        SRAM word-address width
// PORTS
//   CLK          in   1       system clock, all logic on posedge
//   RST_N        in   1       asynchronous active-low reset
//   START        in   1       1-cycle pulse: restart playback at address 0, tempo DEFAULT_BPM
//   SRAM_A       out  ADDR_W  SRAM word address (registered)
//   SRAM_RD      out  1       high while a read is in flight; top maps it to CE/OE, WE=1
//   SRAM_D       in   16      SRAM read data
//   NOTE         out  7       current note code to tone generator
//   NOTE_ON      out  1       1 = NOTE sounding, 0 = rest/silence
//   BEAT         out  1       1-cycle pulse per beat
//   PC           out  ADDR_W  address of next instruction to fetch
//   HALTED       out  1       sequencer stopped (HALT opcode or after reset)
// BEHAVIOUR
//   Reset: SRAM_A=0, SRAM_RD=0, NOTE=0, NOTE_ON=0, BEAT=0, PC=0, HALTED=1, bpm=DEFAULT_BPM, acc=0.
//   Instruction: INS[0]=1 note: INS[7:1] note code, INS[15:12] duration in beats (0 means 16),
//     INS[11:8] reserved. INS[0]=0 setting: INS[3:1] opcode:
//     000 SET_BPM: bpm<=INS[15:8]; value 0 is ignored (bpm unchanged)
//     001 JUMP: PC<=INS[15:4] zero-extended
//     010 REST: NOTE_ON<=0 for INS[15:12] beats (0 means 16)
//     111 HALT; other opcodes are NOPs
//   FSM: IDLE -> ADDR -> WAIT -> LATCH -> EXEC -> {PLAY | ADDR | IDLE}.
//     IDLE: HALTED=1. START -> ADDR with PC=0, bpm=DEFAULT_BPM, acc=0, NOTE_ON=0.
//     ADDR: SRAM_A<=PC, SRAM_RD<=1. WAIT: hold SRAM_WAIT cycles. LATCH: ins<=SRAM_D, SRAM_RD<=0,
//       PC<=PC+1 (wraps 2^ADDR_W-1 -> 0).
//     EXEC: note/REST loads remaining<=duration, drives NOTE/NOTE_ON, then goes to PLAY.
//       Settings and NOPs go straight back to ADDR with no beat wait. HALT: NOTE_ON<=0 -> IDLE.
//     PLAY: decrement remaining on each BEAT. When remaining hits 0 -> ADDR.
//       NOTE and NOTE_ON hold through the fetch until the next EXEC; no silence gap.
//   Beat: acc is 32 bits. Each cycle, if acc+bpm >= 60*CLK_HZ then acc<=acc+bpm-60*CLK_HZ and
//     BEAT=1; else acc<=acc+bpm. Free-running in all states except IDLE, where acc=0.
//   Fetch-to-EXEC latency = SRAM_WAIT+3 cycles. A note starts at EXEC and ends on its Nth BEAT.
//   Simultaneous events: START in any state wins over everything and aborts the in-flight read
//     (SRAM_RD<=0 that cycle). BEAT coincident with EXEC is not counted toward the new note.
//   RST_N low mid-read: all outputs go to reset values immediately (async).
//   Setting-loop guard: 256 consecutive non-note instructions force HALT (JUMP-to-self lockup).
// CONFIGURATION
//   SEQ_LOOP_EN defined: HALT opcode loads PC=0, keeps bpm, goes to ADDR (endless loop);
//     HALTED=1 only after reset and before START, and the loop guard still forces IDLE.
//   SEQ_LOOP_EN undefined: HALT -> IDLE, HALTED=1 until next START.
// TESTING
//   1 Reset, no START -> HALTED=1, SRAM_RD=0, NOTE_ON=0, PC=0 indefinitely.
//   2 CLK_HZ=100, bpm=60, mem[0]=0x3015 (note 0x0A, 3 beats) -> NOTE=0x0A, NOTE_ON=1
//     SRAM_WAIT+3 cycles after START. Exactly 3 BEATs 100 cycles apart, then fetch of addr 1.
//   3 mem[0]=0x7800 (SET_BPM 120), mem[1]=0x1003 (note 1,1 beat), CLK_HZ=100 -> BEAT period 50;
//     mem SET_BPM 0 -> period unchanged.
//   4 mem[0]=0x0052 (JUMP 5), mem[5]=0x000E (HALT) -> SRAM_A sequence 0,5; then HALTED=1,
//     NOTE_ON=0. With SEQ_LOOP_EN, SRAM_A returns to 0.
//   5 START pulse during WAIT of a note fetch -> SRAM_RD drops, PC=0, next SRAM_A=0; RST_N pulse
//     mid-PLAY -> all outputs at reset values within the same cycle.
//   6 mem[0]=0x0002 (JUMP 0) -> after 256 fetches HALTED=1, no NOTE_ON.

Source files
------------

// File: rtl/note_sequencer_if.sv
// SRAM read bus between the note sequencer (master) and the score SRAM (slave).
interface note_sequencer_if #(
    parameter int unsigned ADDR_W = 18
);
    logic [ADDR_W-1:0] sram_a;
    logic              sram_rd;
    logic [15:0]       sram_d;

    modport master (output sram_a, output sram_rd, input sram_d);
    modport slave  (input sram_a, input sram_rd, output sram_d);
endinterface

// File: rtl/note_sequencer.sv
// Score playback controller: fetches 16-bit instructions from SRAM, plays notes
// and rests for a number of beats, and generates the beat tick with a phase accumulator.
// Optional macro SEQ_LOOP_EN: the HALT opcode restarts the score at address 0
// instead of stopping.
module note_sequencer #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DEFAULT_BPM = 96,
    parameter int unsigned SRAM_WAIT   = 2,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    note_sequencer_if.master  sram,
    output logic [6:0]        note,
    output logic              note_on,
    output logic              beat,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [31:0] BEAT_THR = 32'(60 * CLK_HZ);
    localparam logic [7:0]  BPM_RST  = 8'(DEFAULT_BPM);
    localparam int unsigned WW       = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SRAM_WAIT - 1);

    localparam logic [2:0] OP_SET_BPM = 3'b000;
    localparam logic [2:0] OP_JUMP    = 3'b001;
    localparam logic [2:0] OP_REST    = 3'b010;
    localparam logic [2:0] OP_HALT    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_EXEC,
        S_PLAY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sram_a_q;
    logic              sram_rd_q;
    logic [WW-1:0]     wait_cnt;
    logic [15:0]       ins;
    logic [7:0]        bpm;
    logic [31:0]       acc;
    logic [4:0]        remaining;
    logic [7:0]        guard_cnt;

    logic              is_note;
    logic [2:0]        opcode;
    logic [4:0]        dur;
    logic              guard_trip;
    logic [32:0]       acc_sum;
    logic              beat_hit;

    assign sram.sram_a  = sram_a_q;
    assign sram.sram_rd = sram_rd_q;

    assign is_note    = ins[0];
    assign opcode     = ins[3:1];
    assign dur        = (ins[15:12] == 4'd0) ? 5'd16 : {1'b0, ins[15:12]};
    assign guard_trip = !is_note && (guard_cnt == 8'hFF);
    assign acc_sum    = {1'b0, acc} + {25'd0, bpm};
    assign beat_hit   = acc_sum >= {1'b0, BEAT_THR};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; START restarts the fetch from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_ADDR;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_ADDR:  state_nxt = S_WAIT;
                S_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = S_LATCH;
                S_LATCH: state_nxt = S_EXEC;
                S_EXEC: begin
                    if (is_note) begin
                        state_nxt = S_PLAY;
                    end else if (guard_trip) begin
                        state_nxt = S_IDLE;
                    end else begin
                        case (opcode)
                            OP_REST: state_nxt = S_PLAY;
`ifdef SEQ_LOOP_EN
                            OP_HALT: state_nxt = S_ADDR;
`else
                            OP_HALT: state_nxt = S_IDLE;
`endif
                            default: state_nxt = S_ADDR;
                        endcase
                    end
                end
                S_PLAY:  if (beat && remaining == 5'd1) state_nxt = S_ADDR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status output derived from the state.
    always_comb begin
        halted = (state == S_IDLE);
    end

    // Beat phase accumulator, parked at zero while idle or restarting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= 32'd0;
            beat <= 1'b0;
        end else if (start || state == S_IDLE) begin
            acc  <= 32'd0;
            beat <= 1'b0;
        end else if (beat_hit) begin
            acc  <= 32'(acc_sum - {1'b0, BEAT_THR});
            beat <= 1'b1;
        end else begin
            acc  <= acc_sum[31:0];
            beat <= 1'b0;
        end
    end

    // Fetch, decode and note-duration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a_q  <= '0;
            sram_rd_q <= 1'b0;
            wait_cnt  <= '0;
            ins       <= 16'd0;
            pc        <= '0;
            bpm       <= BPM_RST;
            note      <= 7'd0;
            note_on   <= 1'b0;
            remaining <= 5'd0;
            guard_cnt <= 8'd0;
        end else if (start) begin
            sram_rd_q <= 1'b0;
            pc        <= '0;
            bpm       <= BPM_RST;
            note_on   <= 1'b0;
            guard_cnt <= 8'd0;
        end else begin
            case (state)
                S_ADDR: begin
                    sram_a_q  <= pc;
                    sram_rd_q <= 1'b1;
                    wait_cnt  <= '0;
                end
                S_WAIT: wait_cnt <= wait_cnt + WW'(1);
                S_LATCH: begin
                    ins       <= sram.sram_d;
                    sram_rd_q <= 1'b0;
                    pc        <= pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    if (is_note) begin
                        note      <= ins[7:1];
                        note_on   <= 1'b1;
                        remaining <= dur;
                        guard_cnt <= 8'd0;
                    end else if (guard_trip) begin
                        note_on <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 8'd1;
                        case (opcode)
                            OP_SET_BPM: if (ins[15:8] != 8'd0) bpm <= ins[15:8];
                            OP_JUMP:    pc <= ADDR_W'(ins[15:4]);
                            OP_REST: begin
                                note_on   <= 1'b0;
                                remaining <= dur;
                            end
                            OP_HALT: begin
                                note_on <= 1'b0;
`ifdef SEQ_LOOP_EN
                                pc      <= '0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_PLAY: if (beat) remaining <= remaining - 5'd1;
                default: ;
            endcase
        end
    end

endmodule
